// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types and bus/register encodings for the hazard controller.
// The bus and register macros are defined here only when the core's sys_defs has not already done so.
`ifndef BUS_NONE
`define BUS_NONE 2'b00
`endif
`ifndef BUS_LOAD
`define BUS_LOAD 2'b01
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'b10
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif

package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN    = 2'd0,
    CTRL_DSTALL = 2'd1,
    CTRL_MWAIT  = 2'd2
  } ctrl_state_t;

  // One scoreboard slot per downstream pipeline register: ID/EX, EX/MEM, MEM/WB.
  localparam int unsigned SB_DEPTH = 3;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rd: `ZERO_REG};

  // Writes to x0 never produce a value, so they are tracked as empty slots.
  function automatic sb_entry_t mk_entry(logic vld, logic [4:0] rd);
    sb_entry_t e;
    e.vld = vld & (rd != `ZERO_REG);
    e.rd  = rd;
    return e;
  endfunction

  function automatic logic src_hit(logic use_rs, logic [4:0] rs, sb_entry_t e);
    return use_rs & (rs != `ZERO_REG) & e.vld & (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination-register scoreboard mirroring ID/EX, EX/MEM and MEM/WB; flags RAW hazards
// for the instruction currently in ID.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RF_WRITE_THROUGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_vld,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_use_rs1,
  input  logic       ID_use_rs2,
  input  logic [4:0] ID_rd,
  input  logic       id_ex_en,
  input  logic       ex_mem_en,
  input  logic       mem_wb_en,
  input  logic       id_ex_bubble,
  output logic       hz
);

  // With a write-through register file the MEM/WB slot is already visible to ID.
  localparam int unsigned NumChk = (RF_WRITE_THROUGH != 0) ? 2 : 3;

  sb_entry_t sb_q [SB_DEPTH];
  logic      hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        sb_q[i] <= SB_EMPTY;
      end
    end else begin
      if (id_ex_en) begin
        sb_q[0] <= mk_entry(ID_vld & ~id_ex_bubble, ID_rd);
      end
      if (ex_mem_en) begin
        sb_q[1] <= sb_q[0];
      end
      if (mem_wb_en) begin
        sb_q[2] <= sb_q[1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(NumChk); i++) begin
      hit = hit | src_hit(ID_use_rs1, ID_rs1, sb_q[i]) | src_hit(ID_use_rs2, ID_rs2, sb_q[i]);
    end
    hz = ID_vld & hit;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller: prioritises memory wait, EX redirect and RAW stalls into per-stage
// load enables and bubble/flush strobes, with a status FSM and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RF_WRITE_THROUGH = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_vld,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             EX_redirect,
  input  logic [1:0]       MEM_mem_cmd,
  input  logic             DM_ready,
  output logic             CTRL_if_en,
  output logic             CTRL_if_id_en,
  output logic             CTRL_id_ex_en,
  output logic             CTRL_ex_mem_en,
  output logic             CTRL_mem_wb_en,
  output logic             CTRL_if_id_flush,
  output logic             CTRL_id_ex_bubble,
  output logic [1:0]       CTRL_state,
  output logic [CNT_W-1:0] CTRL_stall_cnt
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hz;
  logic             mwait;

  hazard_scoreboard #(
    .RF_WRITE_THROUGH(RF_WRITE_THROUGH)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .ID_vld       (ID_vld),
    .ID_rs1       (ID_rs1),
    .ID_rs2       (ID_rs2),
    .ID_use_rs1   (ID_use_rs1),
    .ID_use_rs2   (ID_use_rs2),
    .ID_rd        (ID_rd),
    .id_ex_en     (CTRL_id_ex_en),
    .ex_mem_en    (CTRL_ex_mem_en),
    .mem_wb_en    (CTRL_mem_wb_en),
    .id_ex_bubble (CTRL_id_ex_bubble),
    .hz           (hz)
  );

  assign mwait = (MEM_mem_cmd != `BUS_NONE) & ~DM_ready;

  // A redirect arriving during a memory wait stays in the frozen EX stage and is taken later.
  always_comb begin
    CTRL_if_en        = 1'b1;
    CTRL_if_id_en     = 1'b1;
    CTRL_id_ex_en     = 1'b1;
    CTRL_ex_mem_en    = 1'b1;
    CTRL_mem_wb_en    = 1'b1;
    CTRL_if_id_flush  = 1'b0;
    CTRL_id_ex_bubble = 1'b0;
    state_d           = CTRL_RUN;
    if (rst) begin
      state_d = CTRL_RUN;
    end else if (mwait) begin
      CTRL_if_en     = 1'b0;
      CTRL_if_id_en  = 1'b0;
      CTRL_id_ex_en  = 1'b0;
      CTRL_ex_mem_en = 1'b0;
      CTRL_mem_wb_en = 1'b0;
      state_d        = CTRL_MWAIT;
    end else if (EX_redirect) begin
      CTRL_if_id_flush  = 1'b1;
      CTRL_id_ex_bubble = 1'b1;
    end else if (hz) begin
      CTRL_if_en        = 1'b0;
      CTRL_if_id_en     = 1'b0;
      CTRL_id_ex_bubble = 1'b1;
      state_d           = CTRL_DSTALL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!CTRL_if_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign CTRL_state     = state_q;
  assign CTRL_stall_cnt = stall_cnt_q;

  a_flush_has_bubble : assert property (@(posedge clk) disable iff (rst)
    CTRL_if_id_flush |-> CTRL_id_ex_bubble);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table plus random stimulus against a pipeline model.
module tb_hazard_ctrl;

  typedef struct {
    bit       vld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit [4:0] rd;
    bit       redir;
    bit [1:0] cmd;
    bit       rdy;
    bit [6:0] ctl;  // {if, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
    bit [1:0] st;
    bit [31:0] cnt;
  } vec_t;

  localparam bit [6:0] C_RUN = 7'b1111100;
  localparam bit [6:0] C_HZ  = 7'b0011101;
  localparam bit [6:0] C_RED = 7'b1111111;
  localparam bit [6:0] C_MW  = 7'b0000000;

  logic       clk, rst;
  logic       id_vld, use1, use2, redir, rdy;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] cmd;

  logic        if_en [2], if_id_en [2], id_ex_en [2], ex_mem_en [2], mem_wb_en [2];
  logic        flush [2], bubble [2];
  logic [1:0]  state [2];
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: 0 = write-through, 32-bit; 1 = no write-through, 4-bit.
  int              m_sb [2][3];
  int              m_state [2];
  longint unsigned m_cnt [2];
  longint unsigned m_max [2];

  hazard_ctrl #(.RF_WRITE_THROUGH(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ID_vld(id_vld), .ID_rs1(rs1), .ID_rs2(rs2),
    .ID_use_rs1(use1), .ID_use_rs2(use2), .ID_rd(rd), .EX_redirect(redir),
    .MEM_mem_cmd(cmd), .DM_ready(rdy),
    .CTRL_if_en(if_en[0]), .CTRL_if_id_en(if_id_en[0]), .CTRL_id_ex_en(id_ex_en[0]),
    .CTRL_ex_mem_en(ex_mem_en[0]), .CTRL_mem_wb_en(mem_wb_en[0]),
    .CTRL_if_id_flush(flush[0]), .CTRL_id_ex_bubble(bubble[0]),
    .CTRL_state(state[0]), .CTRL_stall_cnt(cnt0)
  );

  hazard_ctrl #(.RF_WRITE_THROUGH(0), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ID_vld(id_vld), .ID_rs1(rs1), .ID_rs2(rs2),
    .ID_use_rs1(use1), .ID_use_rs2(use2), .ID_rd(rd), .EX_redirect(redir),
    .MEM_mem_cmd(cmd), .DM_ready(rdy),
    .CTRL_if_en(if_en[1]), .CTRL_if_id_en(if_id_en[1]), .CTRL_id_ex_en(id_ex_en[1]),
    .CTRL_ex_mem_en(ex_mem_en[1]), .CTRL_mem_wb_en(mem_wb_en[1]),
    .CTRL_if_id_flush(flush[1]), .CTRL_id_ex_bubble(bubble[1]),
    .CTRL_state(state[1]), .CTRL_stall_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit [6:0] ctl_of(int m);
    return {if_en[m], if_id_en[m], id_ex_en[m], ex_mem_en[m], mem_wb_en[m], flush[m], bubble[m]};
  endfunction

  function automatic longint unsigned cnt_of(int m);
    return (m == 0) ? longint'(cnt0) : longint'(cnt1);
  endfunction

  function automatic vec_t mk(bit vld, int s1, int s2, bit u1, bit u2, int d, bit rdr,
                              int c, bit r, bit [6:0] ctl, int st, int cn);
    vec_t v;
    v.vld = vld; v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.u1 = u1; v.u2 = u2; v.rd = 5'(d);
    v.redir = rdr; v.cmd = 2'(c); v.rdy = r; v.ctl = ctl; v.st = 2'(st); v.cnt = 32'(cn);
    return v;
  endfunction

  // Is register r still pending in a slot that ID cannot yet read from the register file?
  function automatic bit pending(int m, int r);
    int lim = (m == 0) ? 2 : 3;
    if (r == 0) return 1'b0;
    for (int k = 0; k < lim; k++) if (m_sb[m][k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) m_sb[m][k] = 0;
      m_state[m] = 0;
      m_cnt[m] = 0;
    end
  endfunction

  task automatic check_reset_outputs(string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ctl"}, ctl_of(m), C_RUN);
      chk({tag, "_state"}, state[m], 0);
      chk({tag, "_cnt"}, cnt_of(m), 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then registered ones.
  task automatic run_cycle(input vec_t v, input bit use_exp);
    bit [6:0] exp_ctl [2];
    bit mw, hz;
    id_vld = v.vld; rs1 = v.rs1; rs2 = v.rs2; use1 = v.u1; use2 = v.u2; rd = v.rd;
    redir = v.redir; cmd = v.cmd; rdy = v.rdy;
    #1;
    for (int m = 0; m < 2; m++) begin
      mw = (v.cmd != 0) && !v.rdy;
      hz = v.vld && ((v.u1 && pending(m, v.rs1)) || (v.u2 && pending(m, v.rs2)));
      if (mw) exp_ctl[m] = C_MW;
      else if (v.redir) exp_ctl[m] = C_RED;
      else if (hz) exp_ctl[m] = C_HZ;
      else exp_ctl[m] = C_RUN;
      chk((m == 0) ? "ctl_wt" : "ctl_nowt", ctl_of(m), exp_ctl[m]);
      if (!mw) begin
        m_sb[m][2] = m_sb[m][1];
        m_sb[m][1] = m_sb[m][0];
        m_sb[m][0] = (v.vld && !exp_ctl[m][0]) ? int'(v.rd) : 0;
      end
      m_state[m] = mw ? 2 : ((hz && !v.redir) ? 1 : 0);
      if (!exp_ctl[m][6] && m_cnt[m] < m_max[m]) m_cnt[m]++;
    end
    if (use_exp) chk("tab_ctl", ctl_of(0), v.ctl);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk((m == 0) ? "state_wt" : "state_nowt", state[m], m_state[m]);
      chk((m == 0) ? "cnt_wt" : "cnt_nowt", cnt_of(m), m_cnt[m]);
    end
    if (use_exp) begin
      chk("tab_state", state[0], v.st);
      chk("tab_cnt", cnt0, v.cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t tab[$];
    vec_t v;
    m_max[0] = 64'hFFFF_FFFF;
    m_max[1] = 64'hF;
    rst = 1'b1; id_vld = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0; rd = 0;
    redir = 0; cmd = 0; rdy = 0;
    model_reset();

    // lw x5 ; add x6,x5,x1 : two-cycle load-use stall with write-through RF
    tab.push_back(mk(1, 2, 0, 1, 0, 5, 0, 0, 0, C_RUN, 0, 0));
    tab.push_back(mk(1, 5, 1, 1, 1, 6, 0, 0, 0, C_HZ,  1, 1));
    tab.push_back(mk(1, 5, 1, 1, 1, 6, 0, 1, 1, C_HZ,  1, 2));
    tab.push_back(mk(1, 5, 1, 1, 1, 6, 0, 0, 0, C_RUN, 0, 2));
    // add x0,x1,x2 ; sub x7,x0,x0 : x0 never stalls
    tab.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, 0, C_RUN, 0, 2));
    tab.push_back(mk(1, 0, 0, 1, 1, 7, 0, 0, 0, C_RUN, 0, 2));
    // redirect with a dependent instruction in ID: flush + bubble, no stall
    tab.push_back(mk(1, 7, 0, 1, 0, 8, 1, 0, 0, C_RED, 0, 2));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2));
    // load waits 3 cycles with a pending redirect, which flushes only after release
    tab.push_back(mk(1, 9, 0, 1, 0, 9, 1, 1, 0, C_MW,  2, 3));
    tab.push_back(mk(1, 9, 0, 1, 0, 9, 1, 1, 0, C_MW,  2, 4));
    tab.push_back(mk(1, 9, 0, 1, 0, 9, 1, 1, 0, C_MW,  2, 5));
    tab.push_back(mk(1, 9, 0, 1, 0, 9, 1, 1, 1, C_RED, 0, 5));
    tab.push_back(mk(1, 3, 0, 1, 0, 10, 0, 0, 0, C_RUN, 0, 5));
    // consumer of x10 frozen by a memory wait, then reset arrives
    tab.push_back(mk(1, 10, 0, 1, 0, 11, 0, 1, 0, C_MW, 2, 6));

    @(negedge clk);
    do_reset();
    foreach (tab[i]) run_cycle(tab[i], 1'b1);

    // Reset mid-wait drops x10 from the scoreboard: the consumer proceeds.
    do_reset();
    run_cycle(mk(1, 10, 0, 1, 0, 11, 0, 0, 0, C_RUN, 0, 0), 1'b1);

    // Long memory wait saturates the 4-bit counter, 32-bit keeps counting.
    do_reset();
    for (int i = 0; i < 20; i++) run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, C_MW, 2, i + 1), 1'b1);
    chk("sat4", cnt1, 4'hF);
    chk("cnt32_after_wait", cnt0, 20);
    run_cycle(mk(1, 4, 0, 1, 0, 12, 0, 0, 0, C_RUN, 0, 20), 1'b1);
    run_cycle(mk(1, 12, 0, 1, 0, 13, 0, 0, 0, C_HZ, 1, 21), 1'b1);
    chk("sat4_after_stall", cnt1, 4'hF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      v = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 4), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 2), ($urandom_range(0, 2) != 0),
             C_RUN, 0, 0);
      run_cycle(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
